spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//   Transfer sequencer for the SPI master. Owns the SPIF/SPTEF status flags and
//   drives the SPISR status register load (spisr_we/spisr_val). Hands CPU data
//   from the data register to the shift register and generates SCK and per-bit
//   shift strobes. Sits between the CPU bus decode, the shift register and SPISR.
// PARAMETERS
//   DATA_W  8  bits per transfer (>=2)
//   DIV_W   8  width of baud_div and of the internal divider counter
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      synchronous, active-low reset
//   spe         in   1      SPI enable
//   spie        in   1      SPIF interrupt enable
//   sptie       in   1      SPTEF interrupt enable
//   dr_wr       in   1      CPU write strobe, data register
//   dr_rd       in   1      CPU read strobe, data register
//   sr_rd       in   1      CPU read strobe, status register
//   baud_div    in   DIV_W  SCK half-period in clk cycles, minus 1
//   sck         out  1      serial clock, idle 0
//   shift_load  out  1      1-cycle pulse: copy data register into shift register
//   shift_en    out  1      1-cycle pulse: shift one bit
//   rx_capture  out  1      1-cycle pulse: copy shift register into receive buffer
//   busy        out  1      high in LOAD, SHIFT and DONE
//   wcol        out  1      1-cycle pulse: write collision
//   spif        out  1      transfer-complete flag
//   sptef       out  1      transmit-data-register-empty flag
//   spisr_we    out  1      status register load enable
//   spisr_val   out  8      {spif,1'b0,sptef,5'b0}, combinational from flags
//   spi_irq     out  1      interrupt request
// BEHAVIOUR
//   Reset (rst=0 at clk edge): state IDLE, counters 0, sck/shift_load/shift_en/
//     rx_capture/busy/wcol/spif/spi_irq = 0, sptef = 1, spisr_we = 0.
//     spisr_we = 1 in the first cycle after reset release (value 8'h20).
//   spisr_we: registered 1-cycle pulse in the cycle after any change of spif/sptef.
//   dr_wr with sptef=1: sptef <= 0. dr_wr with sptef=0: ignored, wcol pulse next cycle.
//   FSM:
//     IDLE : spe & ~sptef -> LOAD.
//     LOAD : 1 cycle. shift_load=1, sptef<=1, bit_cnt<=0, div_cnt<=0 -> SHIFT.
//     SHIFT: div_cnt 0..baud_div, wraps to 0. At terminal count sck toggles.
//            shift_en pulses on the terminal count where sck falls (1->0);
//            bit_cnt++. The DATA_W-th shift_en -> DONE.
//            Duration: exactly DATA_W*2*(baud_div+1) cycles.
//            baud_div=0 gives SCK = clk/2.
//     DONE : 1 cycle. rx_capture=1, spif<=1.
//            Next state: spe & ~sptef -> LOAD (back-to-back), else IDLE.
//   spif clear, two-step: sr_rd while spif=1 arms. A later dr_rd clears spif
//     and disarms. dr_rd while unarmed: no effect.
//     Set in DONE wins over a same-cycle clear; arm is dropped.
//   baud_div is sampled every cycle. Changing it mid-transfer is legal and
//     takes effect at the next div_cnt compare.
//   spe=0 in any state: next cycle IDLE, counters 0, sck=0, no rx_capture,
//     spif unchanged, sptef forced 1 (pending write discarded).
//     dr_wr is ignored while spe=0.
//   Reset mid-transfer: identical to power-on reset; no strobes emitted.
// CONFIGURATION
//   SPI_IRQ_EN defined:
//     spi_irq registered = spe & ((spie & spif) | (sptie & sptef)).
//     Rises 1 cycle after the qualifying flag sets.
//   SPI_IRQ_EN undefined: spi_irq tied 0; spie/sptie unused. All else identical.
// TESTING
//   1 Hold rst=0 3 cycles, release -> spif=0, sptef=1, sck=0, busy=0;
//     spisr_we=1 once, spisr_val=8'h20.
//   2 spe=1, baud_div=3, dr_wr at t0:
//     - sptef=0 at t0+1, shift_load at t0+1, sptef=1 at t0+2.
//     - 8 shift_en pulses 8 clks apart; SHIFT lasts 64 cycles.
//     - rx_capture in DONE, spif=1, spisr_val=8'hA0.
//   3 dr_wr twice back-to-back with spe=0 first, then spe=1, sptef=0:
//     second write -> wcol pulse, single shift_load.
//   4 spif=1:
//     - dr_rd alone -> spif stays 1.
//     - sr_rd then dr_rd -> spif=0, spisr_we pulse, spisr_val=8'h20.
//   5 Drop spe after 3rd shift_en -> IDLE next cycle, sck=0, no rx_capture,
//     spif unchanged, sptef=1.
//   6 SPI_IRQ_EN defined, spie=1 -> spi_irq=1 one cycle after spif sets.
//     Macro undefined -> spi_irq stays 0 throughout.

Source files
------------

// File: rtl/spi_xfer_ctrl_if.sv
// SPI transfer-controller bus bundle: CPU-side control/strobes, shift-register
// strobes, status flags and the SPISR load port.
//   master : CPU decode / shift register / status side (drives controls)
//   slave  : spi_xfer_ctrl (drives SCK, strobes, flags, status load)
interface spi_xfer_ctrl_if #(
  parameter int unsigned DIV_W = 8
);
  logic             spe;
  logic             spie;
  logic             sptie;
  logic             dr_wr;
  logic             dr_rd;
  logic             sr_rd;
  logic [DIV_W-1:0] baud_div;
  logic             sck;
  logic             shift_load;
  logic             shift_en;
  logic             rx_capture;
  logic             busy;
  logic             wcol;
  logic             spif;
  logic             sptef;
  logic             spisr_we;
  logic [7:0]       spisr_val;
  logic             spi_irq;

  modport master (
    output spe, spie, sptie, dr_wr, dr_rd, sr_rd, baud_div,
    input  sck, shift_load, shift_en, rx_capture, busy, wcol,
           spif, sptef, spisr_we, spisr_val, spi_irq
  );

  modport slave (
    input  spe, spie, sptie, dr_wr, dr_rd, sr_rd, baud_div,
    output sck, shift_load, shift_en, rx_capture, busy, wcol,
           spif, sptef, spisr_we, spisr_val, spi_irq
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer. Owns SPIF/SPTEF, loads SPISR, hands the data
// register to the shift register and generates SCK plus per-bit strobes.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : spi_xfer_ctrl_if.slave (controls in; sck, shift_load, shift_en,
//          rx_capture, busy, wcol, spif, sptef, spisr_we, spisr_val,
//          spi_irq out)
// Build option: define SPI_IRQ_EN to enable the interrupt request output;
// otherwise spi_irq is tied low and spie/sptie are ignored.
module spi_xfer_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  spi_xfer_ctrl_if.slave bus
);

  localparam int unsigned BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             armed;
  logic             rst_pend;

  logic wr_ok;
  logic wcol_nxt;
  logic sptef_nxt;
  logic spif_set;
  logic spif_clr;
  logic spif_nxt;
  logic armed_nxt;

  assign bus.spisr_val = {bus.spif, 1'b0, bus.sptef, 5'b0};

  // Flag next-state: SPTEF write/reload, SPIF set and two-step clear
  always_comb begin
    wr_ok     = bus.spe & bus.dr_wr & bus.sptef;
    wcol_nxt  = bus.spe & bus.dr_wr & ~bus.sptef;
    sptef_nxt = bus.sptef;
    if (!bus.spe || state == LOAD) begin
      sptef_nxt = 1'b1;
    end else if (wr_ok) begin
      sptef_nxt = 1'b0;
    end
    spif_set  = bus.spe & (state == DONE);
    spif_clr  = armed & bus.dr_rd;
    spif_nxt  = bus.spif;
    armed_nxt = armed;
    if (spif_set) begin
      spif_nxt  = 1'b1;
      armed_nxt = 1'b0;
    end else if (spif_clr) begin
      spif_nxt  = 1'b0;
      armed_nxt = 1'b0;
    end else if (bus.sr_rd && bus.spif) begin
      armed_nxt = 1'b1;
    end
  end

  // Sequencer FSM with registered strobes and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      armed          <= 1'b0;
      rst_pend       <= 1'b1;
      bus.sck        <= 1'b0;
      bus.shift_load <= 1'b0;
      bus.shift_en   <= 1'b0;
      bus.rx_capture <= 1'b0;
      bus.busy       <= 1'b0;
      bus.wcol       <= 1'b0;
      bus.spif       <= 1'b0;
      bus.sptef      <= 1'b1;
      bus.spisr_we   <= 1'b0;
    end else begin
      bus.shift_load <= 1'b0;
      bus.shift_en   <= 1'b0;
      bus.rx_capture <= 1'b0;
      bus.wcol       <= wcol_nxt;
      bus.sptef      <= sptef_nxt;
      bus.spif       <= spif_nxt;
      armed          <= armed_nxt;
      // First post-reset cycle reloads SPISR even though the flags are unchanged
      bus.spisr_we   <= rst_pend | (sptef_nxt != bus.sptef) | (spif_nxt != bus.spif);
      rst_pend       <= 1'b0;
      if (!bus.spe) begin
        state    <= IDLE;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        bus.sck  <= 1'b0;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!sptef_nxt) begin
              state          <= LOAD;
              bus.shift_load <= 1'b1;
              bus.busy       <= 1'b1;
            end
          end
          LOAD: begin
            state   <= SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
            bus.sck <= 1'b0;
          end
          SHIFT: begin
            // >= so a baud_div lowered below the running count still wraps now
            if (div_cnt >= bus.baud_div) begin
              div_cnt <= '0;
              bus.sck <= ~bus.sck;
              if (bus.sck) begin
                bus.shift_en <= 1'b1;
                bit_cnt      <= bit_cnt + BIT_W'(1);
                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  state          <= DONE;
                  bus.rx_capture <= 1'b1;
                end
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          DONE: begin
            if (!sptef_nxt) begin
              state          <= LOAD;
              bus.shift_load <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_IRQ_EN
  // Interrupt request follows the registered flags by one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.spi_irq <= 1'b0;
    end else begin
      bus.spi_irq <= bus.spe & ((bus.spie & bus.spif) | (bus.sptie & bus.sptef));
    end
  end
`else
  logic unused_irq_en;
  assign unused_irq_en = bus.spie ^ bus.sptie;
  assign bus.spi_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: reset, full transfer timing, flag clear
// protocol and write collision (table), spe drop, back-to-back, reset mid-run.
module tb_spi_xfer_ctrl;

`ifdef SPI_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic irq_seen;

  spi_xfer_ctrl_if #(.DIV_W(8)) bus ();

  spi_xfer_ctrl #(.DATA_W(8), .DIV_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.spi_irq === 1'b1) irq_seen = 1'b1;
  end

  typedef struct {
    logic       spe, dr_wr, dr_rd, sr_rd;
    logic       e_spif, e_sptef, e_we, e_wcol, e_load, e_busy;
    logic [7:0] e_val;
  } vec_t;

  vec_t vecs [12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n, k, first_se, bad_se, se_cnt, sck_hi, act_cnt;
    checks   = 0;
    errors   = 0;
    irq_seen = 1'b0;

    // spif/sptef/spisr_we/wcol/shift_load/busy/spisr_val after each row
    //           spe  wr   rd   srd  spif sptef we   wcol load busy val
    vecs[0]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'hA0}; // dr_rd unarmed
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'hA0}; // sr_rd arms
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'hA0};
    vecs[3]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h20}; // clear
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h20};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h20}; // no arm
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h20};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h20}; // wr ignored
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h20};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'h00}; // accepted
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,8'h20}; // collision
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h20};

    rst          = 1'b0;
    bus.spe      = 1'b0;
    bus.spie     = 1'b1;
    bus.sptie    = 1'b0;
    bus.dr_wr    = 1'b0;
    bus.dr_rd    = 1'b0;
    bus.sr_rd    = 1'b0;
    bus.baud_div = 8'd3;

    // Reset and release
    repeat (3) tick;
    chk1("rst_sptef", bus.sptef, 1'b1);
    chk1("rst_spif", bus.spif, 1'b0);
    chk1("rst_we", bus.spisr_we, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    tick;
    chk1("rel_we", bus.spisr_we, 1'b1);
    chkn("rel_val", 32'(bus.spisr_val), 32'h20);
    chk1("rel_sck", bus.sck, 1'b0);
    tick;
    chk1("rel_we_once", bus.spisr_we, 1'b0);

    // Full transfer at baud_div=3
    bus.spe = 1'b1;
    tick;
    bus.dr_wr = 1'b1;
    tick;
    bus.dr_wr = 1'b0;
    chk1("t2_sptef0", bus.sptef, 1'b0);
    chk1("t2_load", bus.shift_load, 1'b1);
    chk1("t2_busy", bus.busy, 1'b1);
    tick;
    chk1("t2_sptef1", bus.sptef, 1'b1);
    chk1("t2_load_pulse", bus.shift_load, 1'b0);
    n = 0; first_se = 0; bad_se = 0; se_cnt = 0; sck_hi = 0;
    while (bus.rx_capture !== 1'b1 && n < 200) begin
      tick;
      n++;
      if (bus.sck === 1'b1) sck_hi++;
      if (bus.shift_en === 1'b1) begin
        se_cnt++;
        if (first_se == 0) first_se = n;
        if (n % 8 != 0) bad_se++;
      end
    end
    chkn("t2_shift_len", 32'(n), 32'd64);
    chkn("t2_se_count", 32'(se_cnt), 32'd8);
    chkn("t2_se_first", 32'(first_se), 32'd8);
    chkn("t2_se_spacing", 32'(bad_se), 32'd0);
    chkn("t2_sck_high", 32'(sck_hi), 32'd32);
    chk1("t2_done_busy", bus.busy, 1'b1);
    chk1("t2_done_spif", bus.spif, 1'b0);
    tick;
    chk1("t2_spif", bus.spif, 1'b1);
    chkn("t2_val", 32'(bus.spisr_val), 32'hA0);
    chk1("t2_we", bus.spisr_we, 1'b1);
    chk1("t2_idle", bus.busy, 1'b0);
    chk1("t2_irq_lag", bus.spi_irq, 1'b0);
    tick;
    chk1("t2_irq", bus.spi_irq, IRQ_ON);

    // Table: spif clear protocol and write collision
    for (int i = 0; i < 12; i++) begin
      bus.spe   = vecs[i].spe;
      bus.dr_wr = vecs[i].dr_wr;
      bus.dr_rd = vecs[i].dr_rd;
      bus.sr_rd = vecs[i].sr_rd;
      tick;
      chk1($sformatf("v%0d_spif", i), bus.spif, vecs[i].e_spif);
      chk1($sformatf("v%0d_sptef", i), bus.sptef, vecs[i].e_sptef);
      chk1($sformatf("v%0d_we", i), bus.spisr_we, vecs[i].e_we);
      chk1($sformatf("v%0d_wcol", i), bus.wcol, vecs[i].e_wcol);
      chk1($sformatf("v%0d_load", i), bus.shift_load, vecs[i].e_load);
      chk1($sformatf("v%0d_busy", i), bus.busy, vecs[i].e_busy);
      chkn($sformatf("v%0d_val", i), 32'(bus.spisr_val), 32'(vecs[i].e_val));
    end
    bus.dr_wr = 1'b0;
    bus.dr_rd = 1'b0;
    bus.sr_rd = 1'b0;

    // Drop spe mid-transfer after the 3rd shift, with a write pending
    n = 0; k = 0;
    while (n < 3 && k < 200) begin
      tick;
      k++;
      if (bus.dr_wr === 1'b1) bus.dr_wr = 1'b0;
      if (bus.shift_en === 1'b1) begin
        n++;
        if (n == 1) bus.dr_wr = 1'b1;
      end
    end
    chkn("t5_reach3", 32'(n), 32'd3);
    repeat (5) tick;
    chk1("t5_sck_hi", bus.sck, 1'b1);
    chk1("t5_pending", bus.sptef, 1'b0);
    bus.spe = 1'b0;
    tick;
    chk1("t5_sck0", bus.sck, 1'b0);
    chk1("t5_busy0", bus.busy, 1'b0);
    chk1("t5_sptef1", bus.sptef, 1'b1);
    chk1("t5_spif", bus.spif, 1'b0);
    chk1("t5_no_rx", bus.rx_capture, 1'b0);
    act_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) bus.spe = 1'b1;
      tick;
      if (bus.shift_load === 1'b1 || bus.shift_en === 1'b1 ||
          bus.rx_capture === 1'b1 || bus.busy === 1'b1) act_cnt++;
    end
    chkn("t5_quiet", 32'(act_cnt), 32'd0);

    // Back-to-back transfers at baud_div=0
    bus.baud_div = 8'd0;
    bus.dr_wr = 1'b1;
    tick;
    bus.dr_wr = 1'b0;
    chk1("b2b_load0", bus.shift_load, 1'b1);
    tick;
    bus.dr_wr = 1'b1;
    tick;
    bus.dr_wr = 1'b0;
    chk1("b2b_pend", bus.sptef, 1'b0);
    n = 1;
    while (bus.rx_capture !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chkn("b2b_len0", 32'(n), 32'd16);
    tick;
    chk1("b2b_load1", bus.shift_load, 1'b1);
    chk1("b2b_busy", bus.busy, 1'b1);
    chk1("b2b_spif", bus.spif, 1'b1);
    tick;
    chk1("b2b_sptef", bus.sptef, 1'b1);
    n = 0;
    while (bus.rx_capture !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chkn("b2b_len1", 32'(n), 32'd16);
    tick;
    chk1("b2b_idle", bus.busy, 1'b0);
    chk1("b2b_noload", bus.shift_load, 1'b0);

    // Reset in the middle of a transfer
    bus.baud_div = 8'd3;
    bus.dr_wr = 1'b1;
    tick;
    bus.dr_wr = 1'b0;
    repeat (6) tick;
    rst = 1'b0;
    tick;
    chk1("mr_busy", bus.busy, 1'b0);
    chk1("mr_sck", bus.sck, 1'b0);
    chk1("mr_spif", bus.spif, 1'b0);
    chk1("mr_sptef", bus.sptef, 1'b1);
    chk1("mr_we", bus.spisr_we, 1'b0);
    chk1("mr_irq", bus.spi_irq, 1'b0);
    rst = 1'b1;
    tick;
    chk1("mr_rel_we", bus.spisr_we, 1'b1);
    tick;
    chk1("mr_rel_busy", bus.busy, 1'b0);
    chk1("mr_rel_we_once", bus.spisr_we, 1'b0);

    chk1("irq_activity", irq_seen, IRQ_ON);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
